// File: rtl/iter_div_unit_pkg.sv
// rtl/iter_div_unit_pkg.sv - shared state encoding and constants for the iterative divider
package iter_div_unit_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int W_EXT        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/iter_div_unit_div_step.sv
// rtl/iter_div_unit_div_step.sv - one combinational restoring-division step
module iter_div_unit_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] dq_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] dq_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          qbit;

  // Shift next dividend bit into the partial remainder, trial-subtract, keep or restore.
  // dq holds the not-yet-consumed dividend on top and the growing quotient below.
  always_comb begin
    shifted = {rem_in, dq_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    qbit    = ~diff[XLEN];
    rem_out = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    dq_out  = {dq_in[XLEN-2:0], qbit};
  end

endmodule

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - iterative RV64M divider with handshake, flush and early-out
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            div_sign,
  input  logic            div_32,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN / BPC + 1);
  localparam logic [CW-1:0] LAST_FULL = CW'(XLEN / BPC - 1);
  localparam logic [CW-1:0] LAST_W    = CW'(W_EXT / BPC - 1);

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[W_EXT-1]}};
    r[W_EXT-1:0] = v[W_EXT-1:0];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[W_EXT-1:0] = v[W_EXT-1:0];
    return r;
  endfunction

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            w32_q, q_neg_q, r_neg_q;
  logic [XLEN-1:0] dq_q, pr_q, dvs_q;
  logic [XLEN-1:0] quot_q, rem_q;

  logic            accept;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, dvd_align, min_w, rem_dz;
  logic            a_neg, b_neg, div_zero, ovf, early;
  logic [XLEN-1:0] q_fix, r_fix;
  logic [CW-1:0]   cnt_last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign accept    = in_ready & in_valid & ~flush;
  assign cnt_last  = w32_q ? LAST_W : LAST_FULL;

  // Operand extension, magnitudes and early-out detection on the incoming request
  always_comb begin
    a_ext = rs1_data;
    b_ext = rs2_data;
    if (div_32) begin
      a_ext = div_sign ? sext32(rs1_data) : zext32(rs1_data);
      b_ext = div_sign ? sext32(rs2_data) : zext32(rs2_data);
    end
    a_neg     = div_sign & a_ext[XLEN-1];
    b_neg     = div_sign & b_ext[XLEN-1];
    abs_a     = a_neg ? -a_ext : a_ext;
    abs_b     = b_neg ? -b_ext : b_ext;
    // W ops left-align the 32-bit magnitude so the step chain always consumes from the top bit
    dvd_align = div_32 ? (abs_a << (XLEN - W_EXT)) : abs_a;
    min_w     = div_32 ? sext32(XLEN'(1) << (W_EXT - 1)) : (XLEN'(1) << (XLEN - 1));
    div_zero  = (b_ext == '0);
    ovf       = div_sign & (a_ext == min_w) & (b_ext == '1);
    early     = div_zero | ovf;
    rem_dz    = div_32 ? sext32(rs1_data) : rs1_data;
  end

  // Sign fix-up of the magnitude quotient/remainder, then W-op sign extension
  always_comb begin
    q_fix = q_neg_q ? -dq_q : dq_q;
    r_fix = r_neg_q ? -pr_q : pr_q;
    if (w32_q) begin
      q_fix = sext32(q_fix);
      r_fix = sext32(r_fix);
    end
  end

  logic [XLEN-1:0] chain_pr [BPC+1];
  logic [XLEN-1:0] chain_dq [BPC+1];

  assign chain_pr[0] = pr_q;
  assign chain_dq[0] = dq_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    iter_div_unit_div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (chain_pr[i]),
      .dq_in   (chain_dq[i]),
      .divisor (dvs_q),
      .rem_out (chain_pr[i+1]),
      .dq_out  (chain_dq[i+1])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early ? DONE : CALC;
      CALC:    if (cnt_q == cnt_last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath: latch operands on accept, iterate in CALC, publish results on early-out or FIX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      w32_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dq_q    <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      w32_q   <= div_32;
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
      dq_q    <= dvd_align;
      pr_q    <= '0;
      dvs_q   <= abs_b;
      if (div_zero) begin
        quot_q <= '1;
        rem_q  <= rem_dz;
      end else if (ovf) begin
        quot_q <= a_ext;
        rem_q  <= '0;
      end
    end else if (state_q == CALC && !flush) begin
      cnt_q <= cnt_q + CW'(1);
      dq_q  <= chain_dq[BPC];
      pr_q  <= chain_pr[BPC];
    end else if (state_q == FIX && !flush) begin
      quot_q <= q_fix;
      rem_q  <= r_fix;
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// tb/tb_iter_div_unit.sv - directed scoreboard bench for iter_div_unit (BPC=1 and BPC=4)
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid1, in_valid4;
  logic        div_sign, div_32, flush, out_ready;
  logic [63:0] rs1, rs2;
  logic        in_ready1, in_ready4, ov1, ov4;
  logic [63:0] q1, q4, r1, r4;
  bit          sel;
  logic        in_ready_s, ov_s;
  logic [63:0] q_s, r_s;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign in_ready_s = sel ? in_ready4 : in_ready1;
  assign ov_s       = sel ? ov4 : ov1;
  assign q_s        = sel ? q4 : q1;
  assign r_s        = sel ? r4 : r1;

  iter_div_unit #(.XLEN(64), .BPC(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .div_sign(div_sign), .div_32(div_32), .rs1_data(rs1), .rs2_data(rs2),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .quot(q1), .rem(r1)
  );

  iter_div_unit #(.XLEN(64), .BPC(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .div_sign(div_sign), .div_32(div_32), .rs1_data(rs1), .rs2_data(rs2),
    .flush(flush), .out_valid(ov4), .out_ready(out_ready), .quot(q4), .rem(r4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input bit s4, input bit sgn, input bit w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er,
                        input int elat, input int hold);
    exp_t        e;
    int          n;
    logic [63:0] hq, hr;
    sel = s4; div_sign = sgn; div_32 = w; rs1 = a; rs2 = b;
    chk({tag, "_rdy"}, {63'd0, in_ready_s}, 64'd1);
    if (s4) in_valid4 = 1'b1;
    else    in_valid1 = 1'b1;
    sb.push_back('{tag, eq, er, elat});
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
    div_sign = ~sgn; div_32 = ~w;
    n = 1;
    while (ov_s !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({e.tag, "_quot"}, q_s, e.q);
    chk({e.tag, "_rem"}, r_s, e.r);
    hq = e.q; hr = e.r;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ov"}, {63'd0, ov_s}, 64'd1);
      chk({tag, "_hold_rdy"}, {63'd0, in_ready_s}, 64'd0);
      chk({tag, "_hold_q"}, q_s, hq);
      chk({tag, "_hold_r"}, r_s, hr);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, {63'd0, ov_s}, 64'd0);
    chk({tag, "_rdy_back"}, {63'd0, in_ready_s}, 64'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; in_valid1 = 1'b0; in_valid4 = 1'b0; div_sign = 1'b0; div_32 = 1'b0;
    flush = 1'b0; out_ready = 1'b0; rs1 = '0; rs2 = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", {63'd0, in_ready1}, 64'd1);
    chk("reset_ov", {63'd0, ov1}, 64'd0);
    chk("reset_quot", q1, 64'd0);
    chk("reset_rem", r1, 64'd0);
    chk("reset_rdy4", {63'd0, in_ready4}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("div_m7_2", 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("divu_by0", 0, 0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 0);
    run_op("div_ovf", 0, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'd0, 1, 0);
    run_op("divw_ovf", 0, 1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 64'd0, 1, 0);
    run_op("divuw_max", 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 34, 0);
    run_op("remw_m7_2", 0, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    run_op("divu_big", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
           64'h5555_5555_5555_5555, 64'd0, 66, 0);
    run_op("div_7_m2", 0, 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, 0);
    run_op("divuw_hi", 0, 0, 1, 64'hDEAD_0000_0000_0064, 64'hBEEF_0000_0000_0007,
           64'd14, 64'd2, 34, 0);
    run_op("divuw_by0", 0, 0, 1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1, 0);

    run_op("b4_100_7", 1, 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 18, 5);
    run_op("b4_m100_7", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
           64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 18, 0);
    run_op("b4_divuw", 1, 0, 1, 64'h0000_0000_FFFF_FFF0, 64'h10,
           64'h0000_0000_0FFF_FFFF, 64'd0, 10, 0);

    // flush in the middle of CALC discards the operation
    sel = 1'b0; div_sign = 1'b0; div_32 = 1'b0; rs1 = 64'd1000; rs2 = 64'd7;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_rdy", {63'd0, in_ready1}, 64'd1);
    chk("flush_ov", {63'd0, ov1}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (ov1) seen = 1'b1;
    end
    chk("flush_no_result", {63'd0, seen}, 64'd0);
    run_op("div_9_3", 0, 0, 0, 64'd9, 64'd3, 64'd3, 64'd0, 66, 0);

    // flush together with a request in IDLE: request is dropped
    rs1 = 64'd50; rs2 = 64'd5; flush = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("flush_idle_rdy", {63'd0, in_ready1}, 64'd1);

    // asynchronous reset in the middle of CALC
    rs1 = 64'd1000; rs2 = 64'd7; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_ov", {63'd0, ov1}, 64'd0);
    chk("arst_rdy", {63'd0, in_ready1}, 64'd1);
    chk("arst_quot", q1, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 0, 1, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
           64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 66, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
